// File: rtl/monopix_readout_pkg.sv
// ---------------------------------------------------------------------------
// monopix_readout_pkg
// Shared types and helpers for the MONOPIX readout controller.
//   t_state          : controller FSM states
//   *_lsb functions  : bit offsets of each field inside the {col, te, le, row}
//                      word, computed from the field widths of an instance
//   gray2bin         : width-generic Gray-to-binary conversion (up to 32 bits)
// ---------------------------------------------------------------------------
package monopix_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN_WAIT,
    ST_READ,
    ST_SHIFT,
    ST_STORE
  } t_state;

  // Field offsets in the serial word; row sits in the LSBs.
  function automatic int row_lsb();
    return 0;
  endfunction

  function automatic int le_lsb(input int row_w);
    return row_w;
  endfunction

  function automatic int te_lsb(input int row_w, input int ts_w);
    return row_w + ts_w;
  endfunction

  function automatic int col_lsb(input int row_w, input int ts_w);
    return row_w + 2 * ts_w;
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i within the field,
  // so bits beyond the field width are masked off before folding.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] mask;
    logic [31:0] gm;
    logic [31:0] b;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    gm   = g & mask;
    b    = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/monopix_readout_ctrl_if.sv
// ---------------------------------------------------------------------------
// monopix_readout_ctrl_if
// Valid/ready output stream of the readout controller.
//   dout       : decoded word {col, te, le, row}
//   dout_valid : FIFO head valid
//   dout_ready : consumer accepts the head this cycle
// master = controller side, slave = consumer side.
// DATA_W must equal COL_W+2*TS_W+ROW_W of the connected controller.
// ---------------------------------------------------------------------------
interface monopix_readout_ctrl_if #(
  parameter int DATA_W = 27
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/monopix_sync_fifo.sv
// ---------------------------------------------------------------------------
// monopix_sync_fifo
// Single-clock show-ahead FIFO: the head word is presented on dout_o
// whenever valid_o is high, and pop_i consumes it.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push_i    : write din_i (ignored when full unless popping the same cycle)
//   pop_i     : consume head (ignored when empty)
//   dout_o    : head word, forced to zero while empty
//   valid_o   : FIFO not empty
//   count_o   : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module monopix_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // When full, a push is only accepted together with a pop of the head.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = ~empty;
  assign count_o = count_q;
endmodule

// File: rtl/monopix_readout_ctrl.sv
// ---------------------------------------------------------------------------
// monopix_readout_ctrl
// Readout controller for one MONOPIX flavour. On token it freezes the chip,
// waits WAIT_CYC cycles, pulses READ for READ_CYC cycles, waits SHIFT_DLY
// cycles and deserialises DATA_W bits (MSB first), optionally Gray-decodes
// LE/TE and pushes the word into a show-ahead FIFO. Readouts chain without
// releasing FREEZE while token, en and FIFO space allow.
//   clk_bx, reset : clock, asynchronous active-high reset
//   en            : readout enable
//   token         : chip token (already synchronised)
//   data_in       : chip serial data, MSB first
//   read, freeze  : chip controls
//   busy          : controller not idle
//   word_cnt      : stored words, saturating at 16'hFFFF
//   out_if        : dout/dout_valid/dout_ready stream
// ---------------------------------------------------------------------------
module monopix_readout_ctrl
  import monopix_readout_pkg::*;
#(
  parameter int COL_W       = 6,
  parameter int TS_W        = 6,
  parameter int ROW_W       = 9,
  parameter int WAIT_CYC    = 2,
  parameter int READ_CYC    = 1,
  parameter int SHIFT_DLY   = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int GRAY_DECODE = 1
) (
  input  logic                   clk_bx,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   token,
  input  logic                   data_in,
  output logic                   read,
  output logic                   freeze,
  output logic                   busy,
  output logic [15:0]            word_cnt,
  monopix_readout_ctrl_if.master out_if
);
  localparam int DATA_W    = COL_W + 2 * TS_W + ROW_W;
  localparam int SHIFT_LEN = SHIFT_DLY + DATA_W;
  localparam int CNT_W     = 16;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LE_LSB    = le_lsb(ROW_W);
  localparam int TE_LSB    = te_lsb(ROW_W, TS_W);
  localparam int COL_LSB   = col_lsb(ROW_W, TS_W);

  t_state             state_q;
  logic [CNT_W-1:0]   cyc_q;
  logic [DATA_W-1:0]  sr_q;
  logic               read_q;
  logic               freeze_q;
  logic [15:0]        word_cnt_q;

  logic               push;
  logic               pop;
  logic [AW:0]        fifo_count;
  logic [AW+1:0]      occ_next;
  logic               space;
  logic               go;
  logic [DATA_W-1:0]  fifo_din;
  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_valid;

  logic [COL_W-1:0]   col_raw;
  logic [TS_W-1:0]    te_raw;
  logic [TS_W-1:0]    le_raw;
  logic [ROW_W-1:0]   row_raw;
  logic [TS_W-1:0]    te_st;
  logic [TS_W-1:0]    le_st;

  // FIFO write happens in STORE; read whenever the head is accepted.
  assign push = (state_q == ST_STORE);
  assign pop  = fifo_valid & out_if.dout_ready;

  // Space is judged on the occupancy after this cycle's push/pop, so the
  // word being stored in STORE already counts against the depth.
  assign occ_next = {1'b0, fifo_count} + {{(AW+1){1'b0}}, push}
                  - {{(AW+1){1'b0}}, pop};
  assign space    = (occ_next < (AW+2)'(FIFO_DEPTH));
  assign go       = token & en & space;

  // Field split of the assembled word.
  assign row_raw = sr_q[ROW_W-1:0];
  assign le_raw  = sr_q[LE_LSB +: TS_W];
  assign te_raw  = sr_q[TE_LSB +: TS_W];
  assign col_raw = sr_q[COL_LSB +: COL_W];

  generate
    if (GRAY_DECODE != 0) begin : g_gray
      assign te_st = TS_W'(gray2bin(32'(te_raw), TS_W));
      assign le_st = TS_W'(gray2bin(32'(le_raw), TS_W));
    end else begin : g_raw
      assign te_st = te_raw;
      assign le_st = le_raw;
    end
  endgenerate

  assign fifo_din = {col_raw, te_st, le_st, row_raw};

  // Outputs are updated together with the state transition, so read/freeze
  // track the state held in the following cycle with no combinational path.
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      sr_q     <= '0;
      read_q   <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q  <= ST_TOKEN_WAIT;
            freeze_q <= 1'b1;
            cyc_q    <= '0;
          end
        end
        ST_TOKEN_WAIT: begin
          if (cyc_q == CNT_W'(WAIT_CYC - 1)) begin
            state_q <= ST_READ;
            read_q  <= 1'b1;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_READ: begin
          if (cyc_q == CNT_W'(READ_CYC - 1)) begin
            state_q <= ST_SHIFT;
            read_q  <= 1'b0;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          // The first SHIFT_DLY cycles cover the chip's output latency.
          if (cyc_q >= CNT_W'(SHIFT_DLY)) begin
            sr_q <= {sr_q[DATA_W-2:0], data_in};
          end
          if (cyc_q == CNT_W'(SHIFT_LEN - 1)) begin
            state_q <= ST_STORE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_STORE: begin
          // Chaining keeps freeze high straight into the next TOKEN_WAIT.
          if (go) begin
            state_q <= ST_TOKEN_WAIT;
          end else begin
            state_q  <= ST_IDLE;
            freeze_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          read_q   <= 1'b0;
          freeze_q <= 1'b0;
          cyc_q    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else if (push && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  monopix_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_bx),
    .rst     (reset),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign read              = read_q;
  assign freeze            = freeze_q;
  // busy and freeze are both "not IDLE", so they share one register.
  assign busy              = freeze_q;
  assign word_cnt          = word_cnt_q;
  assign out_if.dout       = fifo_dout;
  assign out_if.dout_valid = fifo_valid;
endmodule

// File: tb/tb_monopix_readout_ctrl.sv
module tb_monopix_readout_ctrl;
  localparam int WAIT   = 2;
  localparam int RDC    = 1;
  localparam int SDLY   = 2;
  localparam int DW     = 27;
  localparam int PERIOD = WAIT + RDC + SDLY + DW + 1;
  localparam logic [DW-1:0] W1 = {6'd2, 6'b000111, 6'b000011, 9'd10};

  logic clk;
  logic reset;
  logic en;
  logic token;
  logic din_a, din_b;
  logic rd_a, rd_b, fr_a, fr_b, busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  monopix_readout_ctrl_if #(.DATA_W(DW)) ifa ();
  monopix_readout_ctrl_if #(.DATA_W(DW)) ifb ();

  monopix_readout_ctrl #(.GRAY_DECODE(1), .FIFO_DEPTH(8)) dut_a (
    .clk_bx(clk), .reset(reset), .en(en), .token(token), .data_in(din_a),
    .read(rd_a), .freeze(fr_a), .busy(busy_a), .word_cnt(cnt_a),
    .out_if(ifa.master));

  monopix_readout_ctrl #(.GRAY_DECODE(0), .FIFO_DEPTH(2)) dut_b (
    .clk_bx(clk), .reset(reset), .en(en), .token(token), .data_in(din_b),
    .read(rd_b), .freeze(fr_b), .busy(busy_b), .word_cnt(cnt_b),
    .out_if(ifb.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] words_a[$], words_b[$];  // words the chip model will send
  logic [DW-1:0] exp_a[$], exp_b[$];      // words the consumer must see, in order
  int sent_a = 0, sent_b = 0;

  function automatic logic [5:0] g2b(input logic [5:0] g);
    logic [5:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b;
  endfunction

  function automatic logic [DW-1:0] xform(input logic [DW-1:0] w, input bit gray);
    logic [5:0] te, le;
    te = w[20:15];
    le = w[14:9];
    if (gray) begin
      te = g2b(te);
      le = g2b(le);
    end
    return {w[26:21], te, le, w[8:0]};
  endfunction

  function automatic logic chip_rd(input int which);
    return (which == 0) ? rd_a : rd_b;
  endfunction

  task automatic set_din(input int which, input logic v);
    if (which == 0) din_a = v;
    else            din_b = v;
  endtask

  task automatic model_clear();
    words_a.delete(); words_b.delete();
    exp_a.delete();   exp_b.delete();
    sent_a = 0;       sent_b = 0;
  endtask

  // Chip model: after READ falls, waits SHIFT_DLY cycles then shifts a word out MSB first.
  task automatic chip_run(input int which);
    logic [DW-1:0] w;
    bit abort;
    forever begin
      @(negedge clk);
      if (!reset && chip_rd(which)) begin
        abort = 0;
        for (int k = 0; k < 64 && chip_rd(which) && !reset; k++) @(negedge clk);
        if (reset) abort = 1;
        if (which == 0) begin
          if (words_a.size() != 0) w = words_a.pop_front(); else w = DW'($urandom);
        end else begin
          if (words_b.size() != 0) w = words_b.pop_front(); else w = DW'($urandom);
        end
        for (int k = 0; k < SDLY && !abort; k++) begin
          @(negedge clk);
          if (reset) abort = 1;
        end
        for (int i = DW - 1; i >= 0 && !abort; i--) begin
          set_din(which, w[i]);
          @(negedge clk);
          if (reset) abort = 1;
        end
        set_din(which, 1'b0);
        if (!abort) begin
          if (which == 0) begin exp_a.push_back(xform(w, 1'b1)); sent_a++; end
          else            begin exp_b.push_back(xform(w, 1'b0)); sent_b++; end
        end
      end
    end
  endtask

  initial chip_run(0);
  initial chip_run(1);

  // Scoreboards: every accepted head word is compared with the model stream.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ifa.dout_valid && ifa.dout_ready) begin
        if (exp_a.size() == 0) check_val("a_unexpected_word", 32'(exp_a.size()), 1);
        else begin
          $display("txn a dout=%h", ifa.dout);
          check_val("a_dout", 32'(ifa.dout), 32'(exp_a.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ifb.dout_valid && ifb.dout_ready) begin
        if (exp_b.size() == 0) check_val("b_unexpected_word", 32'(exp_b.size()), 1);
        else begin
          $display("txn b dout=%h", ifb.dout);
          check_val("b_dout", 32'(ifb.dout), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    token = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  int rd_first, rd_n, fr_first, fr_last, fr_n, val_first;
  int rd_pos[4];
  int rd_k;
  logic rd_prev;
  logic [DW-1:0] held;

  initial begin
    reset = 1'b1; en = 1'b0; token = 1'b0; din_a = 1'b0; din_b = 1'b0;
    ifa.dout_ready = 1'b0; ifb.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_read",   32'(rd_a), 0);
    check_val("rst_freeze", 32'(fr_a), 0);
    check_val("rst_busy",   32'(busy_a), 0);
    check_val("rst_valid",  32'(ifa.dout_valid), 0);
    check_val("rst_dout",   32'(ifa.dout), 0);
    check_val("rst_cnt",    32'(cnt_a), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word, both decode flavours
    en = 1'b1;
    words_a.push_back(W1); words_b.push_back(W1);
    @(posedge clk); #1;
    token = 1'b1;
    rd_first = -1; rd_n = 0; fr_first = -1; fr_last = -1; fr_n = 0; val_first = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) token = 1'b0;
      if (rd_a) begin if (rd_first < 0) rd_first = c; rd_n++; end
      if (fr_a) begin if (fr_first < 0) fr_first = c; fr_last = c; fr_n++; end
      if (ifa.dout_valid && val_first < 0) val_first = c;
    end
    check_val("single_read_first", 32'(rd_first), 32'(1 + WAIT));
    check_val("single_read_len",   32'(rd_n), 32'(RDC));
    check_val("single_freeze_first", 32'(fr_first), 1);
    check_val("single_freeze_last",  32'(fr_last), 32'(PERIOD));
    check_val("single_freeze_len",   32'(fr_n), 32'(PERIOD));
    check_val("single_valid_rise",   32'(val_first), 32'(PERIOD + 1));
    check_val("single_dout_gray", 32'(ifa.dout), 32'({6'd2, 6'd5, 6'd2, 9'd10}));
    check_val("single_dout_raw",  32'(ifb.dout), 32'({6'd2, 6'd7, 6'd3, 9'd10}));
    check_val("single_cnt",  32'(cnt_a), 1);
    check_val("single_idle", 32'(busy_a), 0);
    held = ifa.dout;
    repeat (3) @(negedge clk);
    check_val("hold_stable", 32'(ifa.dout), 32'(held));
    @(posedge clk); #1;
    ifa.dout_ready = 1'b1; ifb.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("single_drained", 32'(ifa.dout_valid), 0);

    // Chaining: three words back to back
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      words_a.push_back(w); words_b.push_back(w);
    end
    @(posedge clk); #1;
    token = 1'b1;
    fr_n = 0; rd_k = 0; rd_prev = 1'b0;
    for (int c = 0; c < 3 * PERIOD + 6; c++) begin
      @(negedge clk);
      if (c == 2 * PERIOD + 5) token = 1'b0;
      if (c >= 1 && c <= 3 * PERIOD && fr_a) fr_n++;
      if (rd_a && !rd_prev) begin
        if (rd_k < 4) rd_pos[rd_k] = c;
        rd_k++;
      end
      rd_prev = rd_a;
    end
    check_val("chain_freeze_nogap", 32'(fr_n), 32'(3 * PERIOD));
    check_val("chain_read_pulses",  32'(rd_k), 3);
    check_val("chain_read0", 32'(rd_pos[0]), 32'(1 + WAIT));
    check_val("chain_read1", 32'(rd_pos[1] - rd_pos[0]), 32'(PERIOD));
    check_val("chain_read2", 32'(rd_pos[2] - rd_pos[1]), 32'(PERIOD));
    check_val("chain_cnt",  32'(cnt_a), 3);
    check_val("chain_idle", 32'(busy_a), 0);

    // Backpressure on the depth-2 instance
    do_reset();
    ifa.dout_ready = 1'b0; ifb.dout_ready = 1'b0;
    token = 1'b1;
    repeat (2 * PERIOD + 6) @(negedge clk);
    check_val("bp_stored", 32'(cnt_b), 2);
    check_val("bp_idle",   32'(busy_b), 0);
    check_val("bp_valid",  32'(ifb.dout_valid), 1);
    repeat (10) @(negedge clk);
    check_val("bp_still_idle", 32'(busy_b), 0);
    @(posedge clk); #1;
    ifb.dout_ready = 1'b1;
    @(negedge clk);
    check_val("bp_prepop_idle", 32'(fr_b), 0);
    @(posedge clk); #1;
    ifb.dout_ready = 1'b0;
    @(negedge clk);
    check_val("bp_restart_next", 32'(fr_b), 1);
    @(posedge clk); #1;
    token = 1'b0;
    repeat (PERIOD + 5) @(negedge clk);
    check_val("bp_third_word", 32'(cnt_b), 3);
    @(posedge clk); #1;
    ifa.dout_ready = 1'b1; ifb.dout_ready = 1'b1;
    repeat (PERIOD + 10) @(negedge clk);
    check_val("bp_drain_a", 32'(exp_a.size()), 0);
    check_val("bp_drain_b", 32'(exp_b.size()), 0);
    check_val("bp_cnt_a", 32'(cnt_a), 32'(sent_a));

    // en dropped during SHIFT
    do_reset();
    token = 1'b1;
    repeat (12) @(posedge clk);
    #1 en = 1'b0;
    repeat (PERIOD + 5) @(negedge clk);
    check_val("en_drop_cnt",  32'(cnt_a), 1);
    check_val("en_drop_idle", 32'(busy_a), 0);
    check_val("en_drop_freeze", 32'(fr_a), 0);
    @(posedge clk); #1;
    token = 1'b0; en = 1'b1;

    // Reset during SHIFT with one word queued
    do_reset();
    ifa.dout_ready = 1'b0; ifb.dout_ready = 1'b0;
    token = 1'b1;
    repeat (PERIOD + 15) @(posedge clk);
    #1;
    check_val("mid_queued", 32'(ifa.dout_valid), 1);
    reset = 1'b1; token = 1'b0;
    model_clear();
    #1;
    check_val("mid_rst_read",   32'(rd_a), 0);
    check_val("mid_rst_freeze", 32'(fr_a), 0);
    check_val("mid_rst_valid",  32'(ifa.dout_valid), 0);
    check_val("mid_rst_cnt",    32'(cnt_a), 0);
    check_val("mid_rst_dout",   32'(ifa.dout), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    // Random token / enable / ready traffic
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      token = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 19) != 0);
      ifa.dout_ready = ($urandom_range(0, 1) != 0);
      ifb.dout_ready = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    token = 1'b0; en = 1'b1;
    ifa.dout_ready = 1'b1; ifb.dout_ready = 1'b1;
    repeat (3 * PERIOD) @(negedge clk);
    check_val("rnd_drain_a", 32'(exp_a.size()), 0);
    check_val("rnd_drain_b", 32'(exp_b.size()), 0);
    check_val("rnd_cnt_a", 32'(cnt_a), 32'(sent_a));
    check_val("rnd_cnt_b", 32'(cnt_b), 32'(sent_b));
    check_val("rnd_idle_a", 32'(busy_a), 0);
    check_val("rnd_idle_b", 32'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
